// File: rtl/lsu_ctrl_if.sv
// Purpose : bundles for the LSU request/response side and the data-memory side.
// Latency : none (wiring only).
// Backpress: request side uses req_valid/req_ready; memory side has no backpressure.
//
// lsu_req_if : pipeline MEM stage <-> lsu_ctrl
//   flush, req_valid, req_load, req_funct3, req_addr, req_wdata  (pipeline -> lsu)
//   req_ready, resp_valid, resp_data, resp_misalign, resp_fault  (lsu -> pipeline)
// lsu_mem_if : lsu_ctrl <-> data memory
//   mem_stall, mem_op, mem_addr, mem_wdata  (lsu -> memory)
//   mem_rdata                               (memory -> lsu, one cycle after access)

interface lsu_req_if;
    logic        flush;
    logic        req_valid;
    logic        req_ready;
    logic        req_load;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        resp_misalign;
    logic        resp_fault;

    // master: the pipeline issuing requests
    modport master (
        output flush, req_valid, req_load, req_funct3, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_data, resp_misalign, resp_fault
    );
    // slave: the load/store controller
    modport slave (
        input  flush, req_valid, req_load, req_funct3, req_addr, req_wdata,
        output req_ready, resp_valid, resp_data, resp_misalign, resp_fault
    );
endinterface

interface lsu_mem_if #(parameter int ADDR_W = 11);
    logic              mem_stall;
    logic [2:0]        mem_op;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    // master: the load/store controller driving the memory port
    modport master (
        output mem_stall, mem_op, mem_addr, mem_wdata,
        input  mem_rdata
    );
    // slave: the data memory
    modport slave (
        input  mem_stall, mem_op, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/lsu_ctrl.sv
// Purpose : load/store initiator between MEM stage and a 1-cycle synchronous data memory.
// Latency : store/error resp at N+1, in-word load at N+2, word-crossing load at N+3.
// Backpress: one request in flight; req_ready low while a load is outstanding or flush is high.
//
// Ports:
//   clk, nrst : clock (rising edge), async active-low reset
//   req       : lsu_req_if.slave  - request/response handshake with the pipeline
//   mem       : lsu_mem_if.master - op/addr/wdata/stall to memory, rdata back
// Loads always read whole aligned words and extract lanes here; stores pass data
// unshifted and rely on the memory to place the byte/half lanes.

module lsu_ctrl #(
    parameter int ADDR_W         = 11,
    parameter bit MISALIGN_SPLIT = 1'b1
) (
    input  logic      clk,
    input  logic      nrst,
    lsu_req_if.slave  req,
    lsu_mem_if.master mem
);

    // memory op encodings (mem.vh)
    localparam logic [2:0] LOAD_WORD  = 3'b010;
    localparam logic [2:0] STORE_BYTE = 3'b100;
    localparam logic [2:0] STORE_HALF = 3'b101;
    localparam logic [2:0] STORE_WORD = 3'b110;

    typedef enum logic [1:0] {IDLE, LD0, LD1} state_t;

    state_t            r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_word_addr;
    logic [1:0]        r_off;
    logic [2:0]        r_f3;
    logic              r_cross;
    logic [31:0]       r_lo;
    logic              r_resp_vld;
    logic [31:0]       r_resp_dat;
    logic              r_resp_mis;
    logic              r_resp_flt;

    logic              w_ready;
    logic              w_stall;
    logic [2:0]        w_op;
    logic [ADDR_W-1:0] w_addr;
    logic [31:0]       w_wdata;
    logic              w_resp_vld_nxt;
    logic [31:0]       w_resp_dat_nxt;
    logic              w_resp_mis_nxt;
    logic              w_resp_flt_nxt;
    logic              w_load_go;

    // request decode
    logic [1:0]        w_off;
    logic [2:0]        w_f3;
    logic              w_is_h;
    logic              w_is_w;
    logic              w_bad_f3;
    logic              w_oor;
    logic              w_unal;
    logic              w_cross;
    logic [ADDR_W:0]   w_next_word;
    logic              w_fault;
    logic              w_misalign;

    assign w_off  = req.req_addr[1:0];
    assign w_f3   = req.req_funct3;
    assign w_is_h = (w_f3[1:0] == 2'b01);
    assign w_is_w = (w_f3[1:0] == 2'b10);

    // 011/110/111 never legal; BU/HU encodings are load-only
    assign w_bad_f3 = (w_f3 == 3'b011) || (w_f3 == 3'b110) || (w_f3 == 3'b111) ||
                      (!req.req_load && w_f3[2]);
    assign w_oor    = |req.req_addr[31:ADDR_W];
    assign w_unal   = (w_is_h && w_off[0]) || (w_is_w && (w_off != 2'b00));
    // a half at offset 1 stays inside the word; only offset 3 spills over
    assign w_cross  = req.req_load && ((w_is_h && (w_off == 2'b11)) || (w_is_w && (w_off != 2'b00)));

    // carry out of the second word address means it lies beyond the memory
    assign w_next_word = {1'b0, req.req_addr[ADDR_W-1:2], 2'b00} + {{(ADDR_W-2){1'b0}}, 3'b100};

    assign w_fault    = w_oor || w_bad_f3 || (MISALIGN_SPLIT && w_cross && w_next_word[ADDR_W]);
    assign w_misalign = w_unal && (!req.req_load || !MISALIGN_SPLIT);

    // {hi,lo} shifted down to the requested byte, then sized and extended
    function automatic logic [31:0] extract(input logic [31:0] hi, input logic [31:0] lo,
                                            input logic [1:0] off, input logic [2:0] f3);
        logic [63:0] s;
        s = {hi, lo} >> {off, 3'b000};
        case (f3)
            3'b000:  return {{24{s[7]}}, s[7:0]};
            3'b001:  return {{16{s[15]}}, s[15:0]};
            3'b100:  return {24'h0, s[7:0]};
            3'b101:  return {16'h0, s[15:0]};
            default: return s[31:0];
        endcase
    endfunction

    always_comb begin
        w_state_nxt    = r_state;
        w_ready        = 1'b0;
        w_stall        = 1'b1;
        w_op           = LOAD_WORD;
        w_addr         = '0;
        w_wdata        = '0;
        w_resp_vld_nxt = 1'b0;
        w_resp_dat_nxt = '0;
        w_resp_mis_nxt = 1'b0;
        w_resp_flt_nxt = 1'b0;
        w_load_go      = 1'b0;
        case (r_state)
            IDLE: begin
                w_ready = !req.flush;
                if (req.req_valid && w_ready) begin
                    if (w_fault || w_misalign) begin
                        // rejected before touching memory; fault masks misalign
                        w_resp_vld_nxt = 1'b1;
                        w_resp_flt_nxt = w_fault;
                        w_resp_mis_nxt = !w_fault && w_misalign;
                    end else if (req.req_load) begin
                        w_stall     = 1'b0;
                        w_addr      = {req.req_addr[ADDR_W-1:2], 2'b00};
                        w_load_go   = 1'b1;
                        w_state_nxt = LD0;
                    end else begin
                        w_stall = 1'b0;
                        case (w_f3[1:0])
                            2'b00:   w_op = STORE_BYTE;
                            2'b01:   w_op = STORE_HALF;
                            default: w_op = STORE_WORD;
                        endcase
                        w_addr         = req.req_addr[ADDR_W-1:0];
                        w_wdata        = req.req_wdata;
                        w_resp_vld_nxt = 1'b1;
                    end
                end
            end
            LD0: begin
                if (req.flush) begin
                    w_state_nxt = IDLE;
                end else if (r_cross) begin
                    w_stall     = 1'b0;
                    w_addr      = r_word_addr + {{(ADDR_W-3){1'b0}}, 3'b100};
                    w_state_nxt = LD1;
                end else begin
                    w_resp_vld_nxt = 1'b1;
                    w_resp_dat_nxt = extract(32'h0, mem.mem_rdata, r_off, r_f3);
                    w_state_nxt    = IDLE;
                end
            end
            LD1: begin
                w_state_nxt = IDLE;
                if (!req.flush) begin
                    w_resp_vld_nxt = 1'b1;
                    w_resp_dat_nxt = extract(mem.mem_rdata, r_lo, r_off, r_f3);
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state     <= IDLE;
            r_word_addr <= '0;
            r_off       <= '0;
            r_f3        <= '0;
            r_cross     <= 1'b0;
            r_lo        <= '0;
            r_resp_vld  <= 1'b0;
            r_resp_dat  <= '0;
            r_resp_mis  <= 1'b0;
            r_resp_flt  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_resp_vld <= w_resp_vld_nxt;
            r_resp_dat <= w_resp_dat_nxt;
            r_resp_mis <= w_resp_mis_nxt;
            r_resp_flt <= w_resp_flt_nxt;
            if (w_load_go) begin
                r_word_addr <= {req.req_addr[ADDR_W-1:2], 2'b00};
                r_off       <= w_off;
                r_f3        <= w_f3;
                r_cross     <= w_cross && MISALIGN_SPLIT;
            end
            // low word of a crossing load arrives while in LD0
            if (r_state == LD0) begin
                r_lo <= mem.mem_rdata;
            end
        end
    end

    assign req.req_ready     = w_ready;
    assign req.resp_valid    = r_resp_vld;
    assign req.resp_data     = r_resp_dat;
    assign req.resp_misalign = r_resp_mis;
    assign req.resp_fault    = r_resp_flt;

    assign mem.mem_stall = w_stall;
    assign mem.mem_op    = w_op;
    assign mem.mem_addr  = w_addr;
    assign mem.mem_wdata = w_wdata;

endmodule
